// File: rtl/ins_prefetch_buffer.sv
// rtl/ins_prefetch_buffer.sv - instruction prefetch FIFO between IRAM and the control store
//
// Generates IRAM read addresses on its own, prefetches instructions into a
// DEPTH-entry FIFO and hands one instruction per fetch to a registered output.
// A jump flushes queued and in-flight instructions and restarts at jump_addr.
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   defined   - an instruction returning while the FIFO is empty and a fetch is
//               pending goes straight to ins_out (one cycle less latency)
//   undefined - that instruction is pushed into the FIFO as usual
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   iram_addr  IRAM read address (the internal PC)
//   iram_rd    IRAM read strobe
//   ins_in     IRAM read data, valid one cycle after an iram_rd cycle
//   fetch      request for the next instruction
//   jump       one-cycle flush-and-redirect strobe
//   jump_addr  new PC, sampled when jump=1
//   ins_out    registered current instruction
//   ins_valid  ins_out holds a freshly delivered instruction
//   level      registered FIFO occupancy

module ins_prefetch_buffer #(
    parameter int INS_W  = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] iram_addr,
    output logic              iram_rd,
    input  logic [INS_W-1:0]  ins_in,
    input  logic              fetch,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [INS_W-1:0]  ins_out,
    output logic              ins_valid,
    output logic [CNT_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [INS_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W:0]    credit_used;
    logic              bypass;
    logic              push;
    logic              pop;

    // An outstanding read has already reserved a FIFO slot, so the issue
    // decision counts it against the depth. Pops only free credit once level
    // has been updated, which keeps the FIFO from ever overflowing.
    assign credit_used = {1'b0, level} + (CNT_W + 1)'(inflight);
    assign iram_rd     = !rst && !jump && (credit_used < DEPTH_C);
    assign iram_addr   = pc;

`ifdef PREFETCH_BYPASS_EN
    assign bypass = inflight && fetch && !jump && (level == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push = inflight && !jump && !bypass;
    assign pop  = fetch && !jump && (level != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= '0;
            inflight <= 1'b0;
        end else if (jump) begin
            pc       <= jump_addr;
            inflight <= 1'b0;
        end else begin
            inflight <= iram_rd;
            if (iram_rd) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

    // Storage array needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail] <= ins_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else if (jump) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + CNT_W'(1);
            end else if (pop && !push) begin
                level <= level - CNT_W'(1);
            end
        end
    end

    // Pop reads the entry at the old head, so a same-cycle push to the tail
    // cannot disturb the order of delivered instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_out   <= '0;
            ins_valid <= 1'b0;
        end else if (jump) begin
            ins_valid <= 1'b0;
        end else if (bypass) begin
            ins_out   <= ins_in;
            ins_valid <= 1'b1;
        end else if (pop) begin
            ins_out   <= fifo_mem[head];
            ins_valid <= 1'b1;
        end else if (fetch) begin
            ins_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ins_prefetch_buffer.sv
// tb/tb_ins_prefetch_buffer.sv - self-checking bench for ins_prefetch_buffer

module tb_ins_prefetch_buffer;

    localparam int INS_W  = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef PREFETCH_BYPASS_EN
    localparam int JUMP_LAT = 3;
`else
    localparam int JUMP_LAT = 4;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] iram_addr;
    logic              iram_rd;
    logic [INS_W-1:0]  ins_in = '0;
    logic              fetch = 1'b0;
    logic              jump = 1'b0;
    logic [ADDR_W-1:0] jump_addr = '0;
    logic [INS_W-1:0]  ins_out;
    logic              ins_valid;
    logic [CNT_W-1:0]  level;

    ins_prefetch_buffer #(.INS_W(INS_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .iram_addr(iram_addr), .iram_rd(iram_rd),
        .ins_in(ins_in), .fetch(fetch), .jump(jump), .jump_addr(jump_addr),
        .ins_out(ins_out), .ins_valid(ins_valid), .level(level)
    );

    always #5 clk = ~clk;

    // IRAM: synchronous read, data one cycle after the address.
    logic [INS_W-1:0] iram [256];
    always @(posedge clk) ins_in <= iram[iram_addr];

    int vectors = 0;
    int miscompares = 0;

    // Behavioural reference: queue of instructions plus one outstanding read.
    logic [INS_W-1:0]  q[$];
    logic [ADDR_W-1:0] m_pc;
    bit                m_inf;
    logic [ADDR_W-1:0] m_inf_addr;
    logic [INS_W-1:0]  m_out;
    bit                m_valid;

    logic [INS_W-1:0]  obs_out;
    logic              obs_valid;
    logic [CNT_W-1:0]  obs_level;
    logic [INS_W-1:0]  delivered[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = '0; m_inf = 0; m_inf_addr = '0; m_out = '0; m_valid = 0;
    endtask

    // One cycle: drive at negedge, check before the edge, then advance model.
    task automatic step(input logic f, input logic j, input logic [ADDR_W-1:0] ja);
        bit exp_rd;
        bit popped;
        fetch = f; jump = j; jump_addr = ja;
        #1;
        exp_rd = !j && (q.size() + int'(m_inf) < DEPTH);
        chk("iram_rd", 32'(iram_rd), 32'(exp_rd));
        chk("iram_addr", 32'(iram_addr), 32'(m_pc));
        chk("level", 32'(level), 32'(q.size()));
        chk("ins_out", 32'(ins_out), 32'(m_out));
        chk("ins_valid", 32'(ins_valid), 32'(m_valid));
        obs_out = ins_out; obs_valid = ins_valid; obs_level = level;
        @(posedge clk);
        if (j) begin
            q.delete();
            m_inf = 0; m_valid = 0; m_pc = ja;
        end else begin
            popped = 0;
`ifdef PREFETCH_BYPASS_EN
            if (f && q.size() == 0 && m_inf) begin
                m_out = iram[m_inf_addr]; m_valid = 1; popped = 1; m_inf = 0;
            end
`endif
            if (!popped) begin
                if (f && q.size() > 0) begin
                    m_out = q.pop_front(); m_valid = 1;
                    delivered.push_back(m_out);
                end else if (f) begin
                    m_valid = 0;
                end
                if (m_inf) q.push_back(iram[m_inf_addr]);
            end else begin
                delivered.push_back(m_out);
            end
            m_inf = exp_rd;
            m_inf_addr = m_pc;
            if (exp_rd) m_pc = m_pc + 8'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        int first;
        for (int a = 0; a < 256; a++) iram[a] = 8'(a + 8'h10);
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_iram_rd", 32'(iram_rd), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ins_out", 32'(ins_out), 32'd0);
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch right after reset release sees an empty buffer
        step(1'b1, 1'b0, '0);
        chk("post_rst_valid", 32'(obs_valid), 32'd0);

        // Fill with fetch low: addresses step 0..3, level settles at DEPTH
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0);
        chk("full_level", 32'(obs_level), 32'(DEPTH));

        // Stream from full
        delivered.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
        chk("stream_first", 32'(delivered[0]), 32'h10);
        chk("stream_second", 32'(delivered[1]), 32'h11);

        // Get to level 3 then jump to 0x40
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("pre_jump_level", 32'(obs_level), 32'd3);
        step(1'b1, 1'b1, 8'h40);
        delivered.delete();
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, '0);
            if (first == 0 && obs_valid) begin
                first = k;
                chk("jump_data", 32'(obs_out), 32'h50);
            end
        end
        chk("jump_latency", 32'(first), 32'(JUMP_LAT));

        // PC wrap near the top of the address space
        step(1'b0, 1'b1, 8'hFE);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
        delivered.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
        chk("wrap_0", 32'(delivered[0]), 32'(iram[8'hFE]));
        chk("wrap_1", 32'(delivered[1]), 32'(iram[8'hFF]));
        chk("wrap_2", 32'(delivered[2]), 32'(iram[8'h00]));
        chk("wrap_3", 32'(delivered[3]), 32'(iram[8'h01]));

        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_ins_out", 32'(ins_out), 32'd0);
        chk("async_valid", 32'(ins_valid), 32'd0);
        chk("async_level", 32'(level), 32'd0);
        chk("async_addr", 32'(iram_addr), 32'd0);
        chk("async_rd", 32'(iram_rd), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, '0);
        chk("async_post_valid", 32'(obs_valid), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic f, j;
            logic [ADDR_W-1:0] ja;
            f  = ($urandom_range(3, 0) != 0);
            j  = ($urandom_range(15, 0) == 0);
            ja = 8'($urandom);
            step(f, j, ja);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
